// File: rtl/io_pad_arb_pkg.sv
// Shared types, idle pad defaults and the round-robin pick used by the pad-bank arbiter.
package io_pad_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_OWN
    } arb_state_t;

    localparam logic IDLE_PU_DEF = 1'b0;
    localparam logic IDLE_PD_DEF = 1'b1;
    localparam logic IDLE_CS_DEF = 1'b1;

    localparam int RR_MAX = 8;

    // Search starts one past the previous owner and wraps at num_req; first hit wins.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input logic [2:0]        last_owner,
                                                  input int                num_req);
        logic [RR_MAX-1:0] grant;
        logic [2:0]        idx;
        grant = '0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = 3'((32'(last_owner) + k) % num_req);
            if (k <= num_req && grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/io_pad_arb_in_filt.sv
// One pad's input path: a reset-cleared synchroniser chain followed by a stability filter.
module io_in_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic rx_sync_o,
    output logic rx_filt_o
);

    localparam int FCNT_W = $clog2(FILT_CYC + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCNT_W-1:0]      fcnt;
    logic                   filt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Any agreement between sync and filtered value restarts the stability count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fcnt   <= '0;
            filt_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            fcnt <= '0;
        end else if (fcnt == FCNT_W'(FILT_CYC - 1)) begin
            filt_q <= ~filt_q;
            fcnt   <= '0;
        end else begin
            fcnt <= fcnt + FCNT_W'(1);
        end
    end

    assign rx_sync_o = sync_q[SYNC_STAGES-1];
    assign rx_filt_o = filt_q;

endmodule

// File: rtl/io_pad_arb.sv
// Round-robin owner arbitration for a shared tri-state pad bank, with a forced hi-Z
// turnaround between owners and filtered pad inputs back to the core.
module io_pad_arb
    import io_pad_arb_pkg::*;
#(
    parameter int   NUM_PADS    = 8,
    parameter int   NUM_REQ     = 4,
    parameter int   TURN_CYC    = 2,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYC    = 4,
    parameter logic IDLE_PU     = IDLE_PU_DEF,
    parameter logic IDLE_PD     = IDLE_PD_DEF,
    parameter logic IDLE_CS     = IDLE_CS_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    input  logic [NUM_REQ*NUM_PADS-1:0]  req_c2p_i,
    input  logic [NUM_REQ*NUM_PADS-1:0]  req_c2p_en_i,
    input  logic [NUM_REQ-1:0]           req_cs_i,
    input  logic [NUM_REQ-1:0]           req_pu_i,
    input  logic [NUM_REQ-1:0]           req_pd_i,
    output logic [NUM_PADS-1:0]          pad_c2p_o,
    output logic [NUM_PADS-1:0]          pad_c2p_en_o,
    output logic                         pad_cs_o,
    output logic                         pad_pu_o,
    output logic                         pad_pd_o,
    input  logic [NUM_PADS-1:0]          pad_p2c_i,
    output logic [NUM_PADS-1:0]          rx_sync_o,
    output logic [NUM_PADS-1:0]          rx_filt_o,
    output logic                         busy_o
);

    localparam int CNT_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam int OWN_W = $clog2(NUM_REQ);

    arb_state_t         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [NUM_REQ-1:0] gnt, gnt_nx, rr_winner;
    logic [OWN_W-1:0]   last_owner, last_owner_nx, winner_idx;
    logic               any_req, owner_req, turn_done;

    assign any_req   = |req_i;
    assign owner_req = |(req_i & gnt);
    assign turn_done = (cnt == CNT_W'(TURN_CYC - 1));
    assign rr_winner = NUM_REQ'(rr_pick(RR_MAX'(req_i), 3'(last_owner), NUM_REQ));

    always_comb begin
        winner_idx = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (rr_winner[r]) winner_idx = OWN_W'(r);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // last_owner starts at the top index so requester 0 wins the first search.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt        <= '0;
            gnt        <= '0;
            last_owner <= OWN_W'(NUM_REQ - 1);
        end else begin
            cnt        <= cnt_nx;
            gnt        <= gnt_nx;
            last_owner <= last_owner_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        gnt_nx        = gnt;
        last_owner_nx = last_owner;
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nx = ST_TURN;
                    cnt_nx   = '0;
                end
            end
            ST_TURN: begin
                if (turn_done) begin
                    cnt_nx = '0;
                    if (any_req) begin
                        state_nx      = ST_OWN;
                        gnt_nx        = rr_winner;
                        last_owner_nx = winner_idx;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (!owner_req) begin
                    state_nx = ST_TURN;
                    cnt_nx   = '0;
                    gnt_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    // The grant is non-zero only in OWN, so muxing on it also hi-Zs the bank elsewhere.
    always_comb begin
        pad_c2p_o    = '0;
        pad_c2p_en_o = '0;
        pad_cs_o     = IDLE_CS;
        pad_pu_o     = IDLE_PU;
        pad_pd_o     = IDLE_PD;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
                pad_c2p_o    = req_c2p_i[r*NUM_PADS +: NUM_PADS];
                pad_c2p_en_o = req_c2p_en_i[r*NUM_PADS +: NUM_PADS];
                pad_cs_o     = req_cs_i[r];
                pad_pu_o     = req_pu_i[r];
                pad_pd_o     = req_pd_i[r];
            end
        end
    end

    assign gnt_o  = gnt;
    assign busy_o = (state != ST_IDLE);

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_in_filt
        io_in_filt #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC)
        ) u_in_filt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .pad_i     (pad_p2c_i[p]),
            .rx_sync_o (rx_sync_o[p]),
            .rx_filt_o (rx_filt_o[p])
        );
    end

endmodule

// File: tb/tb_io_pad_arb.sv
// Directed bench for io_pad_arb: a vector table for grant sequencing plus hand-written
// sequences for reset during ownership and the input glitch filter.
module tb_io_pad_arb;

    localparam int NUM_PADS = 8;
    localparam int NUM_REQ  = 4;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic [NUM_REQ-1:0]          req_i;
    logic [NUM_REQ-1:0]          gnt_o;
    logic [NUM_REQ*NUM_PADS-1:0] req_c2p_i;
    logic [NUM_REQ*NUM_PADS-1:0] req_c2p_en_i;
    logic [NUM_REQ-1:0]          req_cs_i, req_pu_i, req_pd_i;
    logic [NUM_PADS-1:0]         pad_c2p_o, pad_c2p_en_o;
    logic                        pad_cs_o, pad_pu_o, pad_pd_o;
    logic [NUM_PADS-1:0]         pad_p2c_i;
    logic [NUM_PADS-1:0]         rx_sync_o, rx_filt_o;
    logic                        busy_o;

    always #5 clk_i = ~clk_i;

    io_pad_arb #(
        .NUM_PADS    (NUM_PADS),
        .NUM_REQ     (NUM_REQ),
        .TURN_CYC    (2),
        .SYNC_STAGES (2),
        .FILT_CYC    (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .req_c2p_i    (req_c2p_i),
        .req_c2p_en_i (req_c2p_en_i),
        .req_cs_i     (req_cs_i),
        .req_pu_i     (req_pu_i),
        .req_pd_i     (req_pd_i),
        .pad_c2p_o    (pad_c2p_o),
        .pad_c2p_en_o (pad_c2p_en_o),
        .pad_cs_o     (pad_cs_o),
        .pad_pu_o     (pad_pu_o),
        .pad_pd_o     (pad_pd_o),
        .pad_p2c_i    (pad_p2c_i),
        .rx_sync_o    (rx_sync_o),
        .rx_filt_o    (rx_filt_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] c2p_tab;
    logic [31:0] en_tab;
    logic [3:0]  cs_tab, pu_tab, pd_tab;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic addVec(input logic [3:0] req, input logic [3:0] gnt, input logic busy);
        vec_t v;
        v.req      = req;
        v.exp_gnt  = gnt;
        v.exp_busy = busy;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        req_i = v.req;
    endtask

    // Expected pad controls follow from which requester the bench expects to own the bank.
    task automatic checkOutput(input int idx, input vec_t v);
        logic [7:0] e_c2p, e_en;
        logic       e_cs, e_pu, e_pd;
        e_c2p = '0;
        e_en  = '0;
        e_cs  = 1'b1;
        e_pu  = 1'b0;
        e_pd  = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (v.exp_gnt[r]) begin
                e_c2p = c2p_tab[r*8 +: 8];
                e_en  = en_tab[r*8 +: 8];
                e_cs  = cs_tab[r];
                e_pu  = pu_tab[r];
                e_pd  = pd_tab[r];
            end
        end
        compare($sformatf("vec%0d gnt", idx), 32'(gnt_o), 32'(v.exp_gnt));
        compare($sformatf("vec%0d busy", idx), 32'(busy_o), 32'(v.exp_busy));
        compare($sformatf("vec%0d c2p", idx), 32'(pad_c2p_o), 32'(e_c2p));
        compare($sformatf("vec%0d c2p_en", idx), 32'(pad_c2p_en_o), 32'(e_en));
        compare($sformatf("vec%0d cs/pu/pd", idx), 32'({pad_cs_o, pad_pu_o, pad_pd_o}),
                32'({e_cs, e_pu, e_pd}));
    endtask

    initial begin
        c2p_tab      = 32'h4433_2211;
        en_tab       = 32'hA53C_0FFF;
        cs_tab       = 4'b1010;
        pu_tab       = 4'b0001;
        pd_tab       = 4'b1100;
        req_c2p_i    = c2p_tab;
        req_c2p_en_i = en_tab;
        req_cs_i     = cs_tab;
        req_pu_i     = pu_tab;
        req_pd_i     = pd_tab;
        req_i        = '0;
        pad_p2c_i    = '0;
        rst_i        = 1'b1;
        tick();
        tick();

        compare("reset gnt", 32'(gnt_o), 32'h0);
        compare("reset busy", 32'(busy_o), 32'h0);
        compare("reset c2p_en", 32'(pad_c2p_en_o), 32'h0);
        compare("reset c2p", 32'(pad_c2p_o), 32'h0);
        compare("reset cs/pu/pd", 32'({pad_cs_o, pad_pu_o, pad_pd_o}), 32'b101);
        compare("reset rx_sync", 32'(rx_sync_o), 32'h0);
        compare("reset rx_filt", 32'(rx_filt_o), 32'h0);
        rst_i = 1'b0;

        // Single request, then all four handing off in order 0,1,2,3,0.
        addVec(4'b0000, 4'b0000, 1'b0);
        addVec(4'b0001, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0001, 1'b1);
        addVec(4'b0001, 4'b0001, 1'b1);
        addVec(4'b1111, 4'b0001, 1'b1);
        addVec(4'b1110, 4'b0000, 1'b1);
        addVec(4'b1110, 4'b0000, 1'b1);
        addVec(4'b1110, 4'b0010, 1'b1);
        addVec(4'b1101, 4'b0000, 1'b1);
        addVec(4'b1101, 4'b0000, 1'b1);
        addVec(4'b1101, 4'b0100, 1'b1);
        addVec(4'b1011, 4'b0000, 1'b1);
        addVec(4'b1011, 4'b0000, 1'b1);
        addVec(4'b1011, 4'b1000, 1'b1);
        addVec(4'b0111, 4'b0000, 1'b1);
        addVec(4'b0111, 4'b0000, 1'b1);
        addVec(4'b0111, 4'b0001, 1'b1);
        // Owner 2 holds with 1 pending; 1 then drops mid-turnaround, bank goes idle.
        addVec(4'b0100, 4'b0000, 1'b1);
        addVec(4'b0100, 4'b0000, 1'b1);
        addVec(4'b0100, 4'b0100, 1'b1);
        addVec(4'b0110, 4'b0100, 1'b1);
        addVec(4'b0010, 4'b0000, 1'b1);
        addVec(4'b0000, 4'b0000, 1'b1);
        addVec(4'b0000, 4'b0000, 1'b0);
        addVec(4'b0000, 4'b0000, 1'b0);
        // Only the request present on the final turnaround cycle counts.
        addVec(4'b1000, 4'b0000, 1'b1);
        addVec(4'b0000, 4'b0000, 1'b1);
        addVec(4'b0001, 4'b0001, 1'b1);
        addVec(4'b0001, 4'b0001, 1'b1);
        addVec(4'b0000, 4'b0000, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput(i, vecs[i]);
        end

        // Reset while owning with pads driven and inputs filtered high.
        req_i     = 4'b0001;
        pad_p2c_i = 8'hFF;
        repeat (8) tick();
        compare("pre-reset gnt", 32'(gnt_o), 32'h1);
        compare("pre-reset c2p_en", 32'(pad_c2p_en_o), 32'hFF);
        compare("pre-reset rx_filt", 32'(rx_filt_o), 32'hFF);
        rst_i = 1'b1;
        tick();
        compare("mid-own reset gnt", 32'(gnt_o), 32'h0);
        compare("mid-own reset c2p_en", 32'(pad_c2p_en_o), 32'h0);
        compare("mid-own reset busy", 32'(busy_o), 32'h0);
        compare("mid-own reset rx_filt", 32'(rx_filt_o), 32'h0);
        compare("mid-own reset rx_sync", 32'(rx_sync_o), 32'h0);
        rst_i     = 1'b0;
        pad_p2c_i = 8'h00;
        req_i     = 4'b1111;
        repeat (3) tick();
        compare("post-reset first winner", 32'(gnt_o), 32'h1);
        req_i = 4'b0000;
        repeat (4) tick();
        compare("post-reset idle busy", 32'(busy_o), 32'h0);

        // Three-cycle glitch on pad 0 must not reach the filtered output.
        pad_p2c_i = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) pad_p2c_i = 8'h00;
            compare($sformatf("glitch rx_sync k%0d", k), 32'(rx_sync_o),
                    32'((k >= 2 && k <= 4) ? 1 : 0));
            compare($sformatf("glitch rx_filt k%0d", k), 32'(rx_filt_o), 32'h0);
        end

        // A held change on pad 1 appears filtered six cycles after the pad moves.
        pad_p2c_i = 8'h02;
        for (int k = 1; k <= 8; k++) begin
            tick();
            compare($sformatf("stable rx_sync k%0d", k), 32'(rx_sync_o),
                    32'((k >= 2) ? 2 : 0));
            compare($sformatf("stable rx_filt k%0d", k), 32'(rx_filt_o),
                    32'((k >= 6) ? 2 : 0));
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
